// File: rtl/lut_func_checker_if.sv
// Bus between the LUT function checker and the environment around it.
// master: the checker (drives operands, strobe and status);
// slave:  the environment (drives start and the unit-under-test result).
interface lut_func_checker_if;
  logic       start_i;
  logic [3:0] a_o;
  logic [3:0] b_o;
  logic       clk_e_o;
  logic [3:0] y_i;
  logic       busy_o;
  logic       done_o;
  logic       pass_o;
  logic [8:0] err_cnt_o;
  logic [3:0] fail_a_o;
  logic [3:0] fail_b_o;
  logic [3:0] fail_y_o;

  modport master (
    input  start_i, y_i,
    output a_o, b_o, clk_e_o, busy_o, done_o, pass_o,
           err_cnt_o, fail_a_o, fail_b_o, fail_y_o
  );

  modport slave (
    output start_i, y_i,
    input  a_o, b_o, clk_e_o, busy_o, done_o, pass_o,
           err_cnt_o, fail_a_o, fail_b_o, fail_y_o
  );
endinterface

// File: rtl/lut_func_checker.sv
// Exhaustive 256-vector checker for a registered 4-bit (~A)|(~B) unit.
// Per vector: DRIVE (setup), STROBE (clk_e_o), WAIT_CYCLES wait, CHECK.
// Optional macro LUT_CHK_STOP_ON_ERR_EN: end the sweep at the first mismatch.
module lut_func_checker #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  lut_func_checker_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_STROBE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_idx;
  logic [3:0] r_wait_cnt;
  logic [3:0] r_y_smp;
  logic [8:0] r_err_cnt;
  logic [3:0] r_fail_a;
  logic [3:0] r_fail_b;
  logic [3:0] r_fail_y;
  logic [3:0] w_expected;
  logic       w_mismatch;
  logic       w_last;

  assign w_expected = (~r_idx[7:4]) | (~r_idx[3:0]);
  assign w_mismatch = (r_y_smp != w_expected);
  assign w_last     = (r_idx == 8'hFF);

  assign bus.a_o       = r_idx[7:4];
  assign bus.b_o       = r_idx[3:0];
  assign bus.err_cnt_o = r_err_cnt;
  assign bus.fail_a_o  = r_fail_a;
  assign bus.fail_b_o  = r_fail_b;
  assign bus.fail_y_o  = r_fail_y;

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    w_next      = r_state;
    bus.clk_e_o = 1'b0;
    bus.busy_o  = 1'b0;
    bus.done_o  = 1'b0;
    bus.pass_o  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start_i) w_next = S_DRIVE;
      S_DRIVE: begin
        bus.busy_o = 1'b1;
        w_next     = S_STROBE;
      end
      S_STROBE: begin
        bus.busy_o  = 1'b1;
        bus.clk_e_o = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        bus.busy_o = 1'b1;
        if (r_wait_cnt == '0) w_next = S_CHECK;
      end
      S_CHECK: begin
        bus.busy_o = 1'b1;
`ifdef LUT_CHK_STOP_ON_ERR_EN
        if (w_mismatch || w_last) w_next = S_DONE;
        else                      w_next = S_DRIVE;
`else
        if (w_last) w_next = S_DONE;
        else        w_next = S_DRIVE;
`endif
      end
      S_DONE: begin
        bus.done_o = 1'b1;
        bus.pass_o = (r_err_cnt == '0);
        if (bus.start_i) w_next = S_DRIVE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: vector index, wait timer, result sample, error tracking.
  // y_i is sampled on the edge that closes the last WAIT cycle, so WAIT_CYCLES
  // is exactly the distance from the strobe's end to the sample point; CHECK
  // then compares the held sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx      <= '0;
      r_wait_cnt <= '0;
      r_y_smp    <= '0;
      r_err_cnt  <= '0;
      r_fail_a   <= '0;
      r_fail_b   <= '0;
      r_fail_y   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start_i) begin
            r_idx     <= '0;
            r_err_cnt <= '0;
            r_fail_a  <= '0;
            r_fail_b  <= '0;
            r_fail_y  <= '0;
          end
        end
        S_STROBE: r_wait_cnt <= 4'(WAIT_CYCLES - 1);
        S_WAIT: begin
          if (r_wait_cnt == '0) r_y_smp    <= bus.y_i;
          else                  r_wait_cnt <= r_wait_cnt - 4'd1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_err_cnt <= r_err_cnt + 9'd1;
            if (r_err_cnt == '0) begin
              r_fail_a <= r_idx[7:4];
              r_fail_b <= r_idx[3:0];
              r_fail_y <= r_y_smp;
            end
          end
          if (w_next == S_DRIVE) r_idx <= r_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_func_checker.sv
// Bench for lut_func_checker: a behavioural unit under test with selectable
// fault/latency modes, a sweep-level scoreboard and an operand-order monitor.
module tb_lut_func_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lut_func_checker_if bus ();
  lut_func_checker_if bus1 ();

  lut_func_checker #(.WAIT_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.master)
  );
  lut_func_checker #(.WAIT_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1.master)
  );

  // Unit-under-test models. mode: 0 latency 1, 1 tied 0, 2 tied F, 3 latency 2
  int unsigned mode = 0;
  logic [3:0] u_s1 = '0, u_s2 = '0, v_s1 = '0, v_s2 = '0;
  always @(posedge clk) begin
    if (bus.clk_e_o) u_s1 <= (~bus.a_o) | (~bus.b_o);
    u_s2 <= u_s1;
    if (bus1.clk_e_o) v_s1 <= (~bus1.a_o) | (~bus1.b_o);
    v_s2 <= v_s1;
  end
  assign bus.y_i  = (mode == 0) ? u_s1 : (mode == 1) ? 4'h0 :
                    (mode == 2) ? 4'hF : u_s2;
  assign bus1.y_i = v_s2;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobes of the main DUT must walk the vector index 0,1,2,... in order.
  int unsigned strobe_cnt = 0;
  always @(negedge clk) begin
    if (bus.clk_e_o) begin
      check_val("vec_ab", {bus.a_o, bus.b_o}, 64'(strobe_cnt[7:0]));
      strobe_cnt++;
    end
  end

  typedef struct {
    logic [8:0]  err;
    logic        pass;
    logic [3:0]  fa, fb, fy;
    int unsigned strobes;
    int unsigned cycles;
  } exp_t;
  exp_t sb[$];
  int unsigned t0;

  function automatic logic [3:0] model_y(input int unsigned m, input int unsigned idx);
    logic [7:0] v;
    v = 8'(idx);
    case (m)
      1:       return 4'h0;
      2:       return 4'hF;
      default: return (~v[7:4]) | (~v[3:0]);
    endcase
  endfunction

  task automatic push_expected(input int unsigned m);
    exp_t e;
    logic [7:0] v;
    logic [3:0] f, y;
    e.err = '0; e.fa = '0; e.fb = '0; e.fy = '0;
    e.strobes = 256;
    for (int unsigned i = 0; i < 256; i++) begin
      v = 8'(i);
      f = (~v[7:4]) | (~v[3:0]);
      y = model_y(m, i);
      if (y != f) begin
        if (e.err == 0) begin e.fa = v[7:4]; e.fb = v[3:0]; e.fy = y; end
        e.err++;
`ifdef LUT_CHK_STOP_ON_ERR_EN
        e.strobes = i + 1;
        break;
`endif
      end
    end
    e.pass   = (e.err == 0);
    e.cycles = e.strobes * 5;
    sb.push_back(e);
  endtask

  // Pulse (or raise and keep) start; align t0 to the accepting edge.
  task automatic launch(input bit hold);
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    if (!hold) bus.start_i = 1'b0;
    t0 = cyc;
    strobe_cnt = 0;
    check_val("busy_after_start", 64'(bus.busy_o), 64'd1);
  endtask

  task automatic collect(input bit hold_check);
    exp_t e;
    bit got_done = 0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(negedge clk);
      got_done = bus.done_o;
    end
    e = sb.pop_front();
    if (!got_done) begin
      check_val("done_timeout", 64'd0, 64'd1);
    end else begin
      check_val("err_cnt", 64'(bus.err_cnt_o), 64'(e.err));
      check_val("pass",    64'(bus.pass_o),    64'(e.pass));
      check_val("fail_a",  64'(bus.fail_a_o),  64'(e.fa));
      check_val("fail_b",  64'(bus.fail_b_o),  64'(e.fb));
      check_val("fail_y",  64'(bus.fail_y_o),  64'(e.fy));
      check_val("strobes", 64'(strobe_cnt),    64'(e.strobes));
      check_val("cycles",  64'(cyc - t0),      64'(e.cycles));
      check_val("busy_in_done", 64'(bus.busy_o), 64'd0);
      if (hold_check) begin
        repeat (3) @(negedge clk);
        check_val("done_hold", {bus.done_o, bus.pass_o, bus.err_cnt_o},
                  {e.pass ? 2'b11 : 2'b10, e.err});
      end
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {31'd0, bus.busy_o, bus.done_o, bus.pass_o, bus.clk_e_o,
            bus.a_o, bus.b_o, bus.err_cnt_o, bus.fail_a_o, bus.fail_b_o,
            bus.fail_y_o};
  endfunction

  initial begin
    bit d1;
    int unsigned snap;
    bus.start_i  = 1'b0;
    bus1.start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_outs", all_outs(), 64'd0);
    rst = 1'b0;

    // Correct unit, each fault mode, and latency 2 with WAIT_CYCLES=2
    for (int unsigned m = 0; m < 4; m++) begin
      mode = m;
      push_expected(m);
      launch(1'b0);
      collect(1'b1);
    end

    // WAIT_CYCLES=1 against a latency-2 unit must report mismatches
    @(negedge clk);
    bus1.start_i = 1'b1;
    @(negedge clk);
    bus1.start_i = 1'b0;
    d1 = 0;
    for (int i = 0; i < 2000 && !d1; i++) begin
      @(negedge clk);
      d1 = bus1.done_o;
    end
    check_val("w1_done", 64'(d1), 64'd1);
    check_val("w1_pass", 64'(bus1.pass_o), 64'd0);
    check_val("w1_err_nonzero", 64'(bus1.err_cnt_o != 0), 64'd1);

    // Reset partway through a sweep aborts it with no further strobes
    mode = 0;
    launch(1'b0);
    repeat (599) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midsweep_reset_outs", all_outs(), 64'd0);
    snap = strobe_cnt;
    repeat (40) @(negedge clk);
    check_val("no_strobe_after_reset", 64'(strobe_cnt), 64'(snap));
    check_val("idle_after_reset", all_outs(), 64'd0);

    // start held high: no restart mid-sweep, one DONE cycle, then re-launch
    mode = 1;
    push_expected(1);
    launch(1'b1);
    collect(1'b0);
    strobe_cnt = 0;
    @(negedge clk);
    check_val("restart_done_low", 64'(bus.done_o), 64'd0);
    check_val("restart_busy", 64'(bus.busy_o), 64'd1);
    check_val("restart_err_clr", 64'(bus.err_cnt_o), 64'd0);
    bus.start_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
